// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 completer: one-hot FSM encoding and
// width helpers derived from the data width and the ack timeout.
package apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WAIT = 3'b010,
    ST_RESP = 3'b100
  } state_t;

  // Number of byte lanes on a DATA_WIDTH-wide bus.
  function automatic int STRB_W(input int data_width);
    return data_width / 8;
  endfunction

  // Counter wide enough to hold TIMEOUT; never narrower than one bit.
  function automatic int CNT_W(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage : apb_pkg

// File: rtl/apb4_completer_if.sv
// APB4 bus bundle between a requester (master) and this completer (slave).
interface apb4_completer_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic                          PSEL;
  logic                          PENABLE;
  logic                          PWRITE;
  logic [ADDR_WIDTH-1:0]         PADDR;
  logic [DATA_WIDTH-1:0]         PWDATA;
  logic [STRB_W(DATA_WIDTH)-1:0] PSTRB;
  logic                          PREADY;
  logic [DATA_WIDTH-1:0]         PRDATA;
  logic                          PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );

endinterface : apb4_completer_if

// File: rtl/apb_addr_decode.sv
// Maps an APB byte address onto a register word index and flags addresses
// that fall below the base, beyond the register bank, or off word alignment.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_REGS   = 16
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic [ADDR_WIDTH-1:0] word_idx,
  output logic                  decode_err
);

  localparam int                    LSB        = $clog2(STRB_W(DATA_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W(DATA_WIDTH) - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LIMIT  = ADDR_WIDTH'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] offset;
  logic                  below_base;
  logic                  misaligned;
  logic                  out_of_range;

  // The mask form stays legal for 8-bit data, where there are no low bits to slice.
  always_comb begin
    offset       = paddr - BASE;
    word_idx     = offset >> LSB;
    below_base   = paddr < BASE;
    misaligned   = (offset & ALIGN_MASK) != '0;
    out_of_range = word_idx >= IDX_LIMIT;
    decode_err   = below_base | misaligned | out_of_range;
  end

endmodule : apb_addr_decode

// File: rtl/apb4_completer.sv
// APB4 completer bridging an APB requester to a req/ack register back end,
// with back-end wait states, byte strobes, decode errors and an ack timeout.
module apb4_completer
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_REGS   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  apb4_completer_if.slave               apb,
  output logic                          o_req,
  output logic                          o_wr,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [DATA_WIDTH-1:0]         o_wdata,
  output logic [STRB_W(DATA_WIDTH)-1:0] o_wstrb,
  input  logic                          i_ack,
  input  logic [DATA_WIDTH-1:0]         i_rdata,
  input  logic                          i_err
);

  localparam int SW = STRB_W(DATA_WIDTH);
  localparam int CW = CNT_W(TIMEOUT);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                    req_q, req_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    decode_err;
  logic                    setup;
  logic                    timed_out;

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .NUM_REGS   (NUM_REGS)
  ) u_decode (
    .paddr      (apb.PADDR),
    .word_idx   (word_idx),
    .decode_err (decode_err)
  );

  assign setup     = apb.PSEL && !apb.PENABLE;
  assign cnt_inc   = cnt_q + CW'(1);
  assign timed_out = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (setup) begin
          if (decode_err) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = ST_RESP;
          end else begin
            req_d   = 1'b1;
            wr_d    = apb.PWRITE;
            addr_d  = word_idx;
            wdata_d = apb.PWDATA;
            wstrb_d = apb.PWRITE ? apb.PSTRB : '0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // A dropped PSEL abandons the transfer before any ack or timeout is honoured.
        if (!apb.PSEL) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (i_ack) begin
          req_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = i_err;
          prdata_d  = (wr_q || i_err) ? '0 : i_rdata;
          state_d   = ST_RESP;
        end else if (timed_out) begin
          req_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the reset is asynchronous, so PRESET clears o_req mid-transfer without waiting for PCLK.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PRDATA  = prdata_q;
  assign apb.PSLVERR = pslverr_q;
  assign o_req       = req_q;
  assign o_wr        = wr_q;
  assign o_addr      = addr_q;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;

endmodule : apb4_completer

// File: tb/tb_apb4_completer.sv
// Directed bench for apb4_completer: handshake timing, decode errors,
// timeout, error ack, abort, asynchronous reset and back-to-back writes.
module tb_apb4_completer;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = 2;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb4_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  logic          o_req;
  logic          o_wr;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata;
  logic [SW-1:0] o_wstrb;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  apb4_completer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (0),
    .NUM_REGS   (16),
    .TIMEOUT    (15)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .apb     (apb),
    .o_req   (o_req),
    .o_wr    (o_wr),
    .o_addr  (o_addr),
    .o_wdata (o_wdata),
    .o_wstrb (o_wstrb),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .i_err   (i_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic          cap_wr;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_wstrb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Runs one APB transfer starting just after a clock edge. ack_cyc=0 means no ack.
  // Cycle c is the cycle following setup-sample edge E1 by c-1 edges.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input int ack_cyc, input logic [DW-1:0] rdata,
                      input logic err, output int ready_cyc, output int req_cnt,
                      output logic [DW-1:0] rd, output logic slverr);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = wr;
    apb.PADDR   = addr;
    apb.PWDATA  = wdata;
    apb.PSTRB   = strb;
    ready_cyc   = -1;
    req_cnt     = 0;
    rd          = 'x;
    slverr      = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      i_ack   = 1'b0;
      i_rdata = '0;
      i_err   = 1'b0;
      if (apb.PREADY) begin
        ready_cyc = c;
        rd        = apb.PRDATA;
        slverr    = apb.PSLVERR;
        break;
      end
      if (o_req) begin
        req_cnt++;
        if (c == 1) begin
          cap_wr    = o_wr;
          cap_addr  = o_addr;
          cap_wdata = o_wdata;
          cap_wstrb = o_wstrb;
        end
      end
      if (c == ack_cyc) begin
        i_ack   = 1'b1;
        i_rdata = rdata;
        i_err   = err;
      end
    end
    @(posedge PCLK); #1;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
  endtask

  int            rc, qc;
  logic [DW-1:0] rd;
  logic          se;

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;
    i_ack = 1'b0; i_rdata = '0; i_err = 1'b0;

    #3;
    check("rst_pready",  32'(apb.PREADY),  32'h0);
    check("rst_prdata",  32'(apb.PRDATA),  32'h0);
    check("rst_pslverr", 32'(apb.PSLVERR), 32'h0);
    check("rst_req",     32'(o_req),       32'h0);
    check("rst_addr",    32'(o_addr),      32'h0);
    check("rst_wstrb",   32'(o_wstrb),     32'h0);
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Write 0x1234 to 0x0004, ack in cycle 1.
    xfer(1'b1, 16'h0004, 16'h1234, 2'b11, 1, 16'h0000, 1'b0, rc, qc, rd, se);
    check("w1_ready_cyc", 32'(rc),        32'd2);
    check("w1_req_cnt",   32'(qc),        32'd1);
    check("w1_wr",        32'(cap_wr),    32'h1);
    check("w1_addr",      32'(cap_addr),  32'h2);
    check("w1_wdata",     32'(cap_wdata), 32'h1234);
    check("w1_wstrb",     32'(cap_wstrb), 32'h3);
    check("w1_pslverr",   32'(se),        32'h0);
    check("w1_prdata",    32'(rd),        32'h0);
    check("w1_idle_ready", 32'(apb.PREADY), 32'h0);
    check("w1_idle_req",  32'(o_req),     32'h0);

    // Read 0x0006, ack after 3 cycles of o_req.
    xfer(1'b0, 16'h0006, 16'hFFFF, 2'b11, 3, 16'hBEEF, 1'b0, rc, qc, rd, se);
    check("r1_ready_cyc", 32'(rc),        32'd4);
    check("r1_req_cnt",   32'(qc),        32'd3);
    check("r1_wr",        32'(cap_wr),    32'h0);
    check("r1_addr",      32'(cap_addr),  32'h3);
    check("r1_wstrb",     32'(cap_wstrb), 32'h0);
    check("r1_prdata",    32'(rd),        32'hBEEF);
    check("r1_pslverr",   32'(se),        32'h0);
    check("r1_idle_prdata", 32'(apb.PRDATA), 32'h0);

    // Misaligned and out-of-range addresses.
    xfer(1'b1, 16'h0021, 16'h7777, 2'b11, 1, 16'h0000, 1'b0, rc, qc, rd, se);
    check("mis_ready_cyc", 32'(rc), 32'd1);
    check("mis_req_cnt",   32'(qc), 32'd0);
    check("mis_pslverr",   32'(se), 32'h1);
    check("mis_prdata",    32'(rd), 32'h0);
    xfer(1'b0, 16'h0020, 16'h0000, 2'b00, 1, 16'h1111, 1'b0, rc, qc, rd, se);
    check("oor_ready_cyc", 32'(rc), 32'd1);
    check("oor_req_cnt",   32'(qc), 32'd0);
    check("oor_pslverr",   32'(se), 32'h1);
    check("oor_prdata",    32'(rd), 32'h0);
    check("oor_addr_hold", 32'(o_addr), 32'h3);

    // Read with no ack: timeout after 15 WAIT cycles.
    xfer(1'b0, 16'h0008, 16'h0000, 2'b00, 0, 16'h0000, 1'b0, rc, qc, rd, se);
    check("to_ready_cyc", 32'(rc), 32'd16);
    check("to_req_cnt",   32'(qc), 32'd15);
    check("to_pslverr",   32'(se), 32'h1);
    check("to_prdata",    32'(rd), 32'h0);
    // Late ack in cycle 17 must be ignored.
    i_ack = 1'b1; i_rdata = 16'hDEAD;
    @(posedge PCLK); #1;
    i_ack = 1'b0; i_rdata = '0;
    check("late_req",    32'(o_req),       32'h0);
    check("late_pready", 32'(apb.PREADY),  32'h0);
    check("late_prdata", 32'(apb.PRDATA),  32'h0);

    // Ack carrying an error.
    xfer(1'b0, 16'h0002, 16'h0000, 2'b00, 2, 16'h5555, 1'b1, rc, qc, rd, se);
    check("err_ready_cyc", 32'(rc), 32'd3);
    check("err_pslverr",   32'(se), 32'h1);
    check("err_prdata",    32'(rd), 32'h0);

    // PSEL dropped in WAIT: o_req falls, no response.
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 16'h0008;
    @(posedge PCLK); #1;
    check("abort_req_up", 32'(o_req), 32'h1);
    apb.PSEL = 1'b0;
    @(posedge PCLK); #1;
    check("abort_req_dn", 32'(o_req),      32'h0);
    check("abort_ready",  32'(apb.PREADY), 32'h0);
    @(posedge PCLK); #1;
    check("abort_no_resp", 32'(apb.PREADY), 32'h0);

    // Asynchronous reset while in WAIT.
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 16'h0008; apb.PWDATA = 16'hCAFE; apb.PSTRB = 2'b11;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    check("prst_req_up", 32'(o_req), 32'h1);
    #2 PRESET = 1'b1;
    #1;
    check("prst_req",   32'(o_req),      32'h0);
    check("prst_wdata", 32'(o_wdata),    32'h0);
    check("prst_addr",  32'(o_addr),     32'h0);
    check("prst_ready", 32'(apb.PREADY), 32'h0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    // Write with PSTRB=0 is forwarded unchanged.
    xfer(1'b1, 16'h000A, 16'h00AA, 2'b00, 1, 16'h0000, 1'b0, rc, qc, rd, se);
    check("post_rst_ready_cyc", 32'(rc),        32'd2);
    check("post_rst_addr",      32'(cap_addr),  32'h5);
    check("post_rst_wdata",     32'(cap_wdata), 32'h00AA);
    check("post_rst_wstrb",     32'(cap_wstrb), 32'h0);
    check("post_rst_pslverr",   32'(se),        32'h0);

    // Back-to-back writes.
    xfer(1'b1, 16'h000C, 16'hA5A5, 2'b01, 1, 16'h0000, 1'b0, rc, qc, rd, se);
    check("b2b1_ready_cyc", 32'(rc),        32'd2);
    check("b2b1_addr",      32'(cap_addr),  32'h6);
    check("b2b1_wdata",     32'(cap_wdata), 32'hA5A5);
    check("b2b1_wstrb",     32'(cap_wstrb), 32'h1);
    xfer(1'b1, 16'h001E, 16'h5A5A, 2'b10, 2, 16'h0000, 1'b0, rc, qc, rd, se);
    check("b2b2_ready_cyc", 32'(rc),        32'd3);
    check("b2b2_req_cnt",   32'(qc),        32'd2);
    check("b2b2_addr",      32'(cap_addr),  32'hF);
    check("b2b2_wdata",     32'(cap_wdata), 32'h5A5A);
    check("b2b2_wstrb",     32'(cap_wstrb), 32'h2);
    check("b2b2_pslverr",   32'(se),        32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_apb4_completer
